// File: rtl/washer_panel.sv
// Washer front panel: synchronises and debounces three active-low keys and runs the IDLE/RUN/HALT panel FSM.
// Optional key-acknowledge buzzer is built only when WASHER_PANEL_BEEP_EN is defined; otherwise beep is tied low.
module washer_panel #(
    parameter int DEB_CYC  = 20,
    parameter int BEEP_CYC = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_select,
    input  logic       key_start,
    input  logic       key_estop,
    input  logic       done,
    output logic       select,
    output logic [1:0] mode,
    output logic       start,
    output logic       emergency,
    output logic       busy,
    output logic       beep
);

    localparam int CW = (DEB_CYC > 1) ? $clog2(DEB_CYC + 1) : 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALT} state_t;

    logic [2:0] w_raw;
    logic [2:0] w_fall;
    logic       w_estop_lvl;
    logic       r_settled;

    assign w_raw = {key_estop, key_start, key_select};

    // Marks that the synchroniser has sampled the real key level at least once since reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_settled <= 1'b0;
        else      r_settled <= 1'b1;
    end

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_key
            logic          r_sync1;
            logic          r_sync2;
            logic          r_deb;
            logic          r_arm;
            logic [CW-1:0] r_cnt;

            // A key held through reset release stays unarmed until it has been seen released.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    r_sync1 <= 1'b1;
                    r_sync2 <= 1'b1;
                    r_deb   <= 1'b1;
                    r_arm   <= 1'b0;
                    r_cnt   <= '0;
                end else begin
                    r_sync1 <= w_raw[gi];
                    r_sync2 <= r_sync1;
                    if (r_settled && r_sync1)
                        r_arm <= 1'b1;
                    if (r_sync2 == r_deb) begin
                        r_cnt <= '0;
                    end else if (r_cnt == CW'(DEB_CYC - 1)) begin
                        r_deb <= r_sync2;
                        r_cnt <= '0;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
            end

            assign w_fall[gi] = r_arm && r_deb && !r_sync2 && (r_cnt == CW'(DEB_CYC - 1));

            if (gi == 2) begin : g_estop_lvl
                assign w_estop_lvl = r_deb;
            end
        end
    endgenerate

    state_t     r_state;
    state_t     w_state_next;
    logic [1:0] r_mode;
    logic [1:0] w_mode_next;
    logic       r_select;
    logic       w_select_next;
    logic       r_start;
    logic       r_emergency;
    logic       r_busy;

    logic w_done_act;
    logic w_go_halt;
    logic w_go_run;
    logic w_resume;
    logic w_step;

    // Priority estop > done > start > select: a lower event is blocked by any higher one present.
    assign w_go_halt  = w_fall[2];
    assign w_done_act = !w_fall[2] && (r_state == S_RUN) && done;
    assign w_go_run   = !w_fall[2] && !w_done_act && w_fall[1] &&
                        (r_state == S_IDLE) && (r_mode != 2'd0);
    assign w_resume   = !w_fall[2] && !w_done_act && w_fall[1] &&
                        (r_state == S_HALT) && w_estop_lvl;
    assign w_step     = !w_fall[2] && !w_done_act && !w_fall[1] && w_fall[0] &&
                        (r_state == S_IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_mode      <= 2'd0;
            r_select    <= 1'b1;
            r_start     <= 1'b0;
            r_emergency <= 1'b1;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_mode      <= w_mode_next;
            r_select    <= w_select_next;
            r_start     <= (w_state_next == S_RUN);
            r_emergency <= (w_state_next != S_HALT);
            r_busy      <= (w_state_next != S_IDLE);
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (w_go_halt)
            w_state_next = S_HALT;
        else if (w_done_act)
            w_state_next = S_IDLE;
        else if (w_go_run)
            w_state_next = S_RUN;
        else if (w_resume)
            w_state_next = S_IDLE;
    end

    always_comb begin
        w_mode_next   = r_mode;
        w_select_next = 1'b1;
        if (w_done_act) begin
            w_mode_next = 2'd0;
        end else if (w_step) begin
            w_mode_next   = r_mode + 2'd1;
            w_select_next = 1'b0;
        end
    end

    assign select    = r_select;
    assign mode      = r_mode;
    assign start     = r_start;
    assign emergency = r_emergency;
    assign busy      = r_busy;

`ifdef WASHER_PANEL_BEEP_EN
    localparam int BW = (BEEP_CYC > 1) ? $clog2(BEEP_CYC + 1) : 1;

    logic          w_act;
    logic          r_beep;
    logic [BW-1:0] r_beep_cnt;

    assign w_act = w_go_halt || w_go_run || w_resume || w_step;

    // Counter holds the cycles still to go after the current one; a new acting press reloads it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_beep     <= 1'b0;
            r_beep_cnt <= '0;
        end else if (w_act) begin
            r_beep     <= 1'b1;
            r_beep_cnt <= BW'(BEEP_CYC - 1);
        end else if (r_beep_cnt != '0) begin
            r_beep     <= 1'b1;
            r_beep_cnt <= r_beep_cnt - BW'(1);
        end else begin
            r_beep     <= 1'b0;
        end
    end

    assign beep = r_beep;
`else
    assign beep = 1'b0;
`endif

endmodule

// File: doc/washer_panel.md
WASHER_PANEL -- requirements
Module: washer_panel

Interface
REQ-001 Parameter DEB_CYC, default 20, is the number of consecutive stable clk cycles needed to accept a key level change.
REQ-002 Parameter BEEP_CYC, default 8, is the beep pulse length in clk cycles.
REQ-003 The module SHALL have these ports:
- clk  input  1  single system clock; all logic on its rising edge.
- rst  input  1  asynchronous active-low reset.
- key_select  input  1  raw mode key; active-low; asynchronous to clk.
- key_start  input  1  raw start key; active-low; asynchronous to clk.
- key_estop  input  1  raw emergency key; active-low; asynchronous to clk.
- done  input  1  wash controller alarm; high means the programme has finished.
- select  output  1  active-low mode-step pulse to the controller.
- mode  output  2  panel copy of the selected mode: 0 standby, 1 rinse, 2 full wash, 3 spin.
- start  output  1  run level to the controller; high while a programme runs.
- emergency  output  1  active-low emergency level to the controller.
- busy  output  1  high in RUN or HALT.
- beep  output  1  key-acknowledge buzzer pulse.

Function
REQ-004 Each key SHALL pass through a 2-flop synchroniser, then a debouncer.
REQ-005 The debounced level SHALL change only after the synchronised level differs from it for DEB_CYC consecutive cycles; any bounce restarts the count.
REQ-006 A press event SHALL be a one-cycle strobe on a debounced 1->0 transition.
- Latency from a clean raw edge to the strobe is DEB_CYC+2 cycles.
REQ-007 The FSM SHALL have exactly three states: IDLE, RUN and HALT.
REQ-008 In IDLE, a select press SHALL advance mode as 0->1->2->3->0 (wrap) and drive select low for exactly one cycle.
REQ-009 In IDLE, a start press with mode!=0 SHALL enter RUN and set start=1 on the next cycle.
- A start press with mode==0 SHALL be ignored.
REQ-010 In RUN, select and start presses SHALL be ignored.
- done==1 SHALL return the FSM to IDLE with start=0 and mode=0.
REQ-011 An estop press in any state SHALL enter HALT with start=0 and emergency=0; mode is held.
REQ-012 In HALT, a start press while debounced key_estop is high SHALL enter IDLE with emergency=1.
- All other presses in HALT SHALL be ignored.
REQ-013 When presses coincide in the same cycle, the priority SHALL be estop > done > start > select.
- Only the highest-priority press acts.
REQ-014 busy SHALL be high exactly in RUN and HALT.
REQ-015 Every output SHALL be registered.

Reset
REQ-016 While rst is low, and on the first cycle after rst goes high, the block SHALL hold:
- state IDLE, mode=0, start=0, busy=0, beep=0
- select=1, emergency=1
- debounced levels=1, debounce counters=0, synchronisers=1
REQ-017 Reset asserted mid-RUN or mid-HALT SHALL force the REQ-016 values asynchronously.
- No press event SHALL be generated on reset release while a key is held.

Configuration
REQ-018 With macro WASHER_PANEL_BEEP_EN defined, each press that acts (REQ-008 to REQ-012) SHALL drive beep high for BEEP_CYC cycles.
- A new acting press during a pulse SHALL restart the pulse.
- Ignored presses SHALL not beep.
REQ-019 Without WASHER_PANEL_BEEP_EN, beep SHALL be tied to 0, no beep counter is built, and the port SHALL remain present.

Verification (DEB_CYC=4, BEEP_CYC=3)
REQ-020 The bench SHALL cover at least these scenarios:
- key_select bounces 1,0,1,0 each for 2 cycles, then holds 0 for 10 cycles -> exactly one select low pulse; mode 0->1 at 6 cycles after the stable low.
- 5 clean select presses from reset -> mode sequence 1,2,3,0,1.
- mode=2, start press -> start=1, busy=1; select press -> mode stays 2; done=1 for 1 cycle -> start=0, mode=0, busy=0.
- During RUN, key_estop and key_start pressed in the same cycle -> HALT, emergency=0, start=0; later start press with estop still held -> stays HALT; release estop, then start press -> IDLE, emergency=1.
- rst pulsed low mid-RUN with key_start held -> all REQ-016 values immediately; no start after release.
- With WASHER_PANEL_BEEP_EN: acting press -> beep high 3 cycles; start press at mode 0 -> beep stays 0.
- Without WASHER_PANEL_BEEP_EN: beep stays 0 throughout.
